// File: rtl/req_arbiter16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Purpose  : Shared types and constants for the 16-way request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int N_REQ        = 16;
  localparam int IDX_W        = 4;
  localparam int HOLD_W       = 8;
  localparam int MAX_HOLD_DEF = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // Binary owner index to one-hot grant vector.
  function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/req_arbiter16_if.sv
`default_nettype none
// ============================================================================
// Module   : req_arbiter16_if
// Purpose  : Request/grant bundle between requesters and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface req_arbiter16_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] i_req;
  logic             i_rr_mode;
  logic             i_release;
  logic [N_REQ-1:0] o_grant;
  logic             o_grant_valid;
  logic [IDX_W-1:0] o_grant_id;
  logic             o_timeout;

  // Requester side: drives requests, observes grants.
  modport master (
    output i_req, i_rr_mode, i_release,
    input  o_grant, o_grant_valid, o_grant_id, o_timeout
  );

  // Arbiter side.
  modport slave (
    input  i_req, i_rr_mode, i_release,
    output o_grant, o_grant_valid, o_grant_id, o_timeout
  );
endinterface
`default_nettype wire

// File: rtl/req_arbiter16_prio_pick16.sv
`default_nettype none
// ============================================================================
// Module   : prio_pick16
// Purpose  : Combinational highest-set-bit finder for a 16-bit vector.
// Revision : 1.0 - initial release
// ============================================================================
module prio_pick16 (
  input  wire logic [15:0] i_vec,
  output logic             o_valid,
  output logic [3:0]       o_idx
);

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    o_valid = |i_vec;
    o_idx   = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (i_vec[i]) o_idx = 4'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/req_arbiter16.sv
`default_nettype none
// ============================================================================
// Module   : req_arbiter16
// Purpose  : 16-way arbiter, fixed-priority or round-robin, with hold limit,
//            mandatory one-cycle gap between owners and timeout pulse.
// Revision : 1.0 - initial release
// ============================================================================
module req_arbiter16 #(
  parameter int N_REQ    = arb_pkg::N_REQ,
  parameter int MAX_HOLD = arb_pkg::MAX_HOLD_DEF
) (
  input wire logic        clk,
  input wire logic        rst,
  req_arbiter16_if.slave  bus
);
  import arb_pkg::*;

  localparam logic [HOLD_W-1:0] C_MAX_HOLD = HOLD_W'(MAX_HOLD);

  arb_state_t        r_state;
  logic [N_REQ-1:0]  r_grant;
  logic              r_grant_valid;
  logic [IDX_W-1:0]  r_grant_id;
  logic              r_timeout;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [IDX_W-1:0]  r_last_owner;

  logic [N_REQ-1:0]  w_req;
  logic [N_REQ-1:0]  w_rot;
  logic              w_fix_valid;
  logic [IDX_W-1:0]  w_fix_idx;
  logic              w_rr_valid;
  logic [IDX_W-1:0]  w_rr_idx;
  logic              w_any;
  logic [IDX_W-1:0]  w_win;
  logic              w_owner_req;
  logic              w_hold_max;
  logic              w_exit;

  assign w_req = bus.i_req;

  // Rotate right by last_owner: position 15 of w_rot holds req[last_owner-1],
  // so a highest-bit pick walks downward from there with wrap-around.
  assign w_rot = (w_req >> r_last_owner) |
                 (w_req << (5'(N_REQ) - {1'b0, r_last_owner}));

  prio_pick16 u_pick_fix (
    .i_vec   (w_req),
    .o_valid (w_fix_valid),
    .o_idx   (w_fix_idx)
  );

  prio_pick16 u_pick_rr (
    .i_vec   (w_rot),
    .o_valid (w_rr_valid),
    .o_idx   (w_rr_idx)
  );

  assign w_any       = bus.i_rr_mode ? w_rr_valid : w_fix_valid;
  assign w_win       = bus.i_rr_mode ? (w_rr_idx + r_last_owner) : w_fix_idx;
  assign w_owner_req = w_req[r_last_owner];
  assign w_hold_max  = (r_hold_cnt == C_MAX_HOLD);
  assign w_exit      = bus.i_release || !w_owner_req || w_hold_max;

  // Arbitration FSM; every output is a flop updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_timeout     <= 1'b0;
      r_hold_cnt    <= '0;
      r_last_owner  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_timeout <= 1'b0;
          if (w_any) begin
            r_state       <= GRANT;
            r_last_owner  <= w_win;
            r_grant       <= idx2onehot(w_win);
            r_grant_valid <= 1'b1;
            r_grant_id    <= w_win;
            r_hold_cnt    <= HOLD_W'(1);
          end else begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
          end
        end
        GRANT: begin
          if (w_exit) begin
            r_state       <= GAP;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_hold_cnt    <= '0;
            // Only a pure hold-limit exit counts as a forced release.
            r_timeout     <= w_hold_max && !bus.i_release && w_owner_req;
          end else begin
            r_hold_cnt    <= r_hold_cnt + HOLD_W'(1);
          end
        end
        GAP: begin
          r_state   <= IDLE;
          r_timeout <= 1'b0;
        end
        default: begin
          r_state       <= IDLE;
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
          r_grant_id    <= '0;
          r_timeout     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_grant       = r_grant;
  assign bus.o_grant_valid = r_grant_valid;
  assign bus.o_grant_id    = r_grant_id;
  assign bus.o_timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_req_arbiter16.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_arbiter16
// Purpose  : Scoreboard bench for req_arbiter16 against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_req_arbiter16;

  localparam int MAXH = 15;

  typedef struct {
    logic [15:0] g;
    logic        v;
    logic [3:0]  id;
    logic        to;
  } exp_t;

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;
  exp_t q[$];

  // Reference model state: who owns, how long, whether a gap is pending.
  int m_owner = -1;
  int m_held  = 0;
  bit m_gap   = 0;
  int m_last  = 0;

  req_arbiter16_if bus ();

  req_arbiter16 #(.N_REQ(16), .MAX_HOLD(MAXH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int pick_fixed(input logic [15:0] r);
    for (int i = 15; i >= 0; i--) if (r[i]) return i;
    return -1;
  endfunction

  // Search starts one below the last owner and walks downward with wrap.
  function automatic int pick_rr(input logic [15:0] r, input int last);
    for (int k = 1; k <= 16; k++) begin
      int idx;
      idx = (last - k + 32) % 16;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // Drive one clock edge worth of inputs and predict the post-edge outputs.
  task automatic step(input logic [15:0] r, input logic m, input logic rel);
    exp_t e;
    bus.i_req     = r;
    bus.i_rr_mode = m;
    bus.i_release = rel;
    e.to = 1'b0;
    if (m_owner >= 0) begin
      if (rel || !r[m_owner] || m_held == MAXH) begin
        e.to    = (m_held == MAXH) && !rel && r[m_owner];
        m_owner = -1;
        m_gap   = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (r != 16'h0) begin
      m_owner = m ? pick_rr(r, m_last) : pick_fixed(r);
      m_last  = m_owner;
      m_held  = 1;
    end
    e.v  = (m_owner >= 0);
    e.g  = e.v ? (16'h1 << m_owner) : 16'h0;
    e.id = e.v ? 4'(m_owner) : 4'h0;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; called at a negedge.
  task automatic do_reset_mid();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_grant", 32'(bus.o_grant), 32'h0);
    chk("async_rst_valid", 32'(bus.o_grant_valid), 32'h0);
    chk("async_rst_id", 32'(bus.o_grant_id), 32'h0);
    chk("async_rst_timeout", 32'(bus.o_timeout), 32'h0);
    @(negedge clk);
    rst           = 1'b0;
    bus.i_req     = 16'h0;
    bus.i_release = 1'b0;
    m_owner = -1;
    m_held  = 0;
    m_gap   = 0;
    m_last  = 0;
  endtask

  // Monitor: compare DUT outputs against the queued prediction after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("grant", 32'(bus.o_grant), 32'(e.g));
        chk("grant_valid", 32'(bus.o_grant_valid), 32'(e.v));
        chk("grant_id", 32'(bus.o_grant_id), 32'(e.id));
        chk("timeout", 32'(bus.o_timeout), 32'(e.to));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", n_total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] r;
    rst           = 1'b1;
    bus.i_req     = 16'h0;
    bus.i_rr_mode = 1'b0;
    bus.i_release = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_grant", 32'(bus.o_grant), 32'h0);
    chk("reset_valid", 32'(bus.o_grant_valid), 32'h0);
    chk("reset_id", 32'(bus.o_grant_id), 32'h0);
    chk("reset_timeout", 32'(bus.o_timeout), 32'h0);
    rst = 1'b0;

    // Round-robin sweep with all requesters active, releasing every grant.
    for (int i = 0; i < 17 * 3; i++) step(16'hFFFF, 1'b1, (i % 3) == 1);
    repeat (3) step(16'h0, 1'b0, 1'b0);

    // Fixed priority single-edge request.
    step(16'h00A4, 1'b0, 1'b0);
    repeat (3) step(16'h0, 1'b0, 1'b1);

    // Hold limit reached with request held: forced release and re-grant.
    repeat (20) step(16'h0001, 1'b0, 1'b0);
    repeat (2) step(16'h0, 1'b0, 1'b0);

    // Release coinciding with the hold limit is a normal release.
    step(16'h0001, 1'b0, 1'b0);
    for (int k = 1; k < MAXH; k++) step(16'h0001, 1'b0, 1'b0);
    step(16'h0001, 1'b0, 1'b1);
    repeat (2) step(16'h0, 1'b0, 1'b0);

    // Owner abandons while another requester waits.
    step(16'h0020, 1'b0, 1'b0);
    step(16'h0220, 1'b0, 1'b0);
    repeat (3) step(16'h0200, 1'b0, 1'b0);
    repeat (3) step(16'h0, 1'b0, 1'b0);

    // Reset in the middle of a grant, then round-robin restart.
    step(16'h0100, 1'b0, 1'b0);
    step(16'h0100, 1'b0, 1'b0);
    do_reset_mid();
    step(16'h8001, 1'b1, 1'b0);
    step(16'h8001, 1'b1, 1'b1);
    repeat (2) step(16'h8001, 1'b1, 1'b0);
    step(16'h8001, 1'b1, 1'b1);
    repeat (2) step(16'h0, 1'b1, 1'b0);

    // Randomized traffic with sticky requests and occasional releases.
    r = 16'h0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) begin
        r = 16'($urandom());
        if ($urandom_range(2) == 0) r = r & 16'($urandom());
      end
      step(r, 1'($urandom_range(1)), $urandom_range(9) == 0);
    end
    repeat (3) step(16'h0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_total++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
